// File: rtl/nv_nvdla_sync_evt_pkg.sv
// Shared definitions for the synchronizer event arbiter.
//   evt_state_e : scheduler FSM states (IDLE / SETUP / WAIT)
//   TOW         : width of the ack-timeout counter
//   calc_idw()  : event-ID width for a given requester count (minimum 1)
package nv_nvdla_sync_evt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WAIT  = 2'd2
    } evt_state_e;

    localparam int TOW = 16;

    function automatic int calc_idw(input int num_req);
        int w;
        w = $clog2(num_req);
        if (w < 1) w = 1;
        return w;
    endfunction

endpackage

// File: rtl/nv_nvdla_sync_rr_arb.sv
// Round-robin selector with registered priority pointer.
//   clk, rst       : clock, async active-high reset (rr_ptr -> 0)
//   pend           : pending request bits
//   rr_ptr_update  : pulse; moves the pointer to upd_id + 1 (mod NUM_REQ)
//   upd_id         : index of the requester that just completed
//   winner, valid  : first pending index at or after rr_ptr, and |pend
module nv_nvdla_sync_rr_arb
    import nv_nvdla_sync_evt_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = calc_idw(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] pend,
    input  logic               rr_ptr_update,
    input  logic [IDW-1:0]     upd_id,
    output logic [IDW-1:0]     winner,
    output logic               valid
);

    logic [IDW-1:0] rr_ptr_q;
    logic [IDW-1:0] rr_ptr_d;
    int             best_off;
    int             off;
    int             nxt;

    // Distance of each index from the pointer, wrapping; smallest distance wins.
    always_comb begin
        winner   = '0;
        best_off = NUM_REQ;
        off      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            off = (i - int'(rr_ptr_q) + NUM_REQ) % NUM_REQ;
            if (pend[i] && (off < best_off)) begin
                best_off = off;
                winner   = IDW'(i);
            end
        end
        valid = |pend;
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        nxt      = int'(upd_id) + 1;
        if (nxt >= NUM_REQ) nxt = 0;
        if (rr_ptr_update) rr_ptr_d = IDW'(nxt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rr_ptr_q <= '0;
        else     rr_ptr_q <= rr_ptr_d;
    end

endmodule

// File: rtl/nv_nvdla_sync_evt_arb.sv
// Source-side scheduler sharing one two-phase toggle synchronizer channel
// among NUM_REQ event requesters.
//   nvdla_core_clk, nvdla_core_rst : clock, async active-high reset
//   evt_req     : per-requester event pulses, captured as sticky pending bits
//   ack_sync    : returned ack toggle (already synchronized); only looked at in WAIT
//   err_clr     : clears err_timeout and evt_ovf (a same-cycle set wins)
//   sync_tgl    : request toggle into the synchronizer
//   sync_id     : ID of the in-flight event; changes only on grant
//   evt_done    : one-cycle completion pulse per requester
//   busy        : scheduler in SETUP or WAIT
//   evt_ovf     : sticky; an event merged into an already pending one
//   err_timeout : sticky; ack not returned within TIMEOUT_CYC WAIT cycles
module nv_nvdla_sync_evt_arb
    import nv_nvdla_sync_evt_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int IDW         = calc_idw(NUM_REQ),
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic               nvdla_core_clk,
    input  logic               nvdla_core_rst,
    input  logic [NUM_REQ-1:0] evt_req,
    input  logic               ack_sync,
    input  logic               err_clr,
    output logic               sync_tgl,
    output logic [IDW-1:0]     sync_id,
    output logic [NUM_REQ-1:0] evt_done,
    output logic               busy,
    output logic [NUM_REQ-1:0] evt_ovf,
    output logic               err_timeout
);

    localparam logic [TOW-1:0]     TO_LAST = TOW'(TIMEOUT_CYC - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT = NUM_REQ'(1);

    evt_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] pend_q, pend_d;
    logic [NUM_REQ-1:0] ovf_q, ovf_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               tgl_q, tgl_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [TOW-1:0]     cnt_q, cnt_d;
    logic               err_q, err_d;

    logic [NUM_REQ-1:0] pend_clr;
    logic [NUM_REQ-1:0] ovf_set;
    logic               err_set;
    logic               rr_upd;
    logic [IDW-1:0]     arb_winner;
    logic               arb_valid;

    nv_nvdla_sync_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr_arb (
        .clk           (nvdla_core_clk),
        .rst           (nvdla_core_rst),
        .pend          (pend_q),
        .rr_ptr_update (rr_upd),
        .upd_id        (id_q),
        .winner        (arb_winner),
        .valid         (arb_valid)
    );

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        tgl_d    = tgl_q;
        cnt_d    = cnt_q;
        done_d   = '0;
        pend_clr = '0;
        err_set  = 1'b0;
        rr_upd   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    id_d     = arb_winner;
                    pend_clr = ONE_HOT << arb_winner;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                // sync_id was loaded last cycle, so it is settled before the toggle.
                tgl_d   = ~tgl_q;
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (ack_sync == tgl_q) begin
                    done_d  = ONE_HOT << id_q;
                    rr_upd  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    // No abort on timeout: flag it and keep waiting for the ack.
                    if (cnt_q == TO_LAST) err_set = 1'b1;
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // New events win over a same-cycle grant clear and over err_clr.
        pend_d  = (pend_q & ~pend_clr) | evt_req;
        ovf_set = evt_req & pend_q & ~pend_clr;
        ovf_d   = ovf_set | (err_clr ? '0 : ovf_q);
        err_d   = err_set | (err_q & ~err_clr);
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            ovf_q   <= '0;
            done_q  <= '0;
            tgl_q   <= 1'b0;
            id_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            tgl_q   <= tgl_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign sync_tgl    = tgl_q;
    assign sync_id     = id_q;
    assign evt_done    = done_q;
    assign busy        = (state_q != ST_IDLE);
    assign evt_ovf     = ovf_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_nv_nvdla_sync_evt_arb.sv
// Self-checking bench for nv_nvdla_sync_evt_arb: a cycle-level behavioural
// model is compared against the DUT on every falling edge; directed scenarios
// post hand-computed literal expectations that the same compare process checks.
module tb_nv_nvdla_sync_evt_arb;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int TC  = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   evt_req = '0;
    logic           ack_sync = 1'b0;
    logic           err_clr = 1'b0;
    logic           sync_tgl;
    logic [IDW-1:0] sync_id;
    logic [N-1:0]   evt_done;
    logic           busy;
    logic [N-1:0]   evt_ovf;
    logic           err_timeout;

    nv_nvdla_sync_evt_arb #(.NUM_REQ(N), .IDW(IDW), .TIMEOUT_CYC(TC)) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .evt_req        (evt_req),
        .ack_sync       (ack_sync),
        .err_clr        (err_clr),
        .sync_tgl       (sync_tgl),
        .sync_id        (sync_id),
        .evt_done       (evt_done),
        .busy           (busy),
        .evt_ovf        (evt_ovf),
        .err_timeout    (err_timeout)
    );

    always #5 clk = ~clk;

    // ---------------- counters (written only by the compare process) -------
    int n_chk  = 0;
    int n_pass = 0;
    int cyc_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- literal expectations posted by the stimulus ----------
    string lit_name [256];
    int    lit_act  [256];
    int    lit_exp  [256];
    int    lit_wr = 0;
    bit    tb_done = 1'b0;

    task automatic post(input string nm, input int act, input int exp);
        if (lit_wr < 256) begin
            lit_name[lit_wr] = nm;
            lit_act[lit_wr]  = act;
            lit_exp[lit_wr]  = exp;
            lit_wr++;
        end
    endtask

    // ---------------- ack loopback driver ----------------------------------
    int ack_dly  = 0;
    bit ack_hold = 1'b0;
    bit hist [32];

    initial begin
        for (int i = 0; i < 32; i++) hist[i] = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                for (int i = 0; i < 32; i++) hist[i] = 1'b0;
                ack_sync = 1'b0;
            end else begin
                for (int i = 31; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = sync_tgl;
                if (!ack_hold) ack_sync = hist[ack_dly];
            end
        end
    end

    // ---------------- behavioural model ------------------------------------
    // Tracks the in-flight event as: busy flag, "toggle still to be issued",
    // WAIT cycles elapsed, plus pending/overflow sets and the fairness pointer.
    bit m_pend [N];
    bit m_ovf  [N];
    bit m_busy = 0, m_setup = 0, m_tgl = 0, m_err = 0;
    int m_id = 0, m_rr = 0, m_waited = 0, m_done = -1;

    initial begin
        int grant, done;
        bit eset, oset;
        for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_ovf[i] = 0; end
        forever begin
            @(posedge clk);
            if (rst) begin
                for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_ovf[i] = 0; end
                m_busy = 0; m_setup = 0; m_tgl = 0; m_err = 0;
                m_id = 0; m_rr = 0; m_waited = 0; m_done = -1;
            end else begin
                grant = -1; done = -1; eset = 0;
                if (!m_busy) begin
                    for (int k = 0; k < N; k++)
                        if (grant < 0 && m_pend[(m_rr + k) % N]) grant = (m_rr + k) % N;
                    if (grant >= 0) begin m_id = grant; m_busy = 1; m_setup = 1; end
                end else if (m_setup) begin
                    m_tgl = !m_tgl; m_setup = 0; m_waited = 0;
                end else if (ack_sync == m_tgl) begin
                    done = m_id; m_busy = 0; m_rr = (m_id + 1) % N;
                end else begin
                    if (m_waited == TC - 1) eset = 1;
                    if (m_waited < 65535) m_waited++;
                end
                for (int i = 0; i < N; i++) begin
                    oset = evt_req[i] && m_pend[i] && (i != grant);
                    m_ovf[i]  = oset || (m_ovf[i] && !err_clr);
                    m_pend[i] = (m_pend[i] && (i != grant)) || evt_req[i];
                end
                m_err  = eset || (m_err && !err_clr);
                m_done = done;
            end
        end
    end

    function automatic int ovf_vec();
        int v = 0;
        for (int i = 0; i < N; i++) if (m_ovf[i]) v |= (1 << i);
        return v;
    endfunction

    // ---------------- compare process --------------------------------------
    initial begin
        int lit_rd = 0;
        forever begin
            @(negedge clk);
            cyc_cnt++;
            if (rst) begin
                chk("rst_sync_tgl", int'(sync_tgl), 0);
                chk("rst_sync_id", int'(sync_id), 0);
                chk("rst_evt_done", int'(evt_done), 0);
                chk("rst_busy", int'(busy), 0);
                chk("rst_evt_ovf", int'(evt_ovf), 0);
                chk("rst_err_timeout", int'(err_timeout), 0);
            end else begin
                chk("sync_tgl", int'(sync_tgl), int'(m_tgl));
                chk("sync_id", int'(sync_id), m_id);
                chk("evt_done", int'(evt_done), (m_done >= 0) ? (1 << m_done) : 0);
                chk("busy", int'(busy), int'(m_busy));
                chk("evt_ovf", int'(evt_ovf), ovf_vec());
                chk("err_timeout", int'(err_timeout), int'(m_err));
            end
            while (lit_rd < lit_wr) begin
                chk(lit_name[lit_rd], lit_act[lit_rd], lit_exp[lit_rd]);
                lit_rd++;
            end
            if (cyc_cnt > 60000) begin
                chk("watchdog", 0, 1);
                $display("%0d/%0d checks passed", n_pass, n_chk);
                $finish;
            end
            if (tb_done) begin
                $display("%0d/%0d checks passed", n_pass, n_chk);
                $finish;
            end
        end
    end

    // ---------------- stimulus ---------------------------------------------
    task automatic cyc1();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; evt_req = '0; err_clr = 1'b0;
        repeat (3) cyc1();
        rst = 1'b0;
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    initial begin
        int c, nd, got;
        int order [4];
        int cnt [N];
        bit seen;

        cyc1();
        // ---- single event, ack returns 6 cycles after the toggle ----
        ack_hold = 0; ack_dly = 6;
        do_reset();
        evt_req = 4'b0100; cyc1(); evt_req = '0;   // cycle 1: pending captured
        post("single_busy_c1", int'(busy), 0);
        cyc1();                                     // cycle 2: granted
        post("single_id_c2", int'(sync_id), 2);
        post("single_busy_c2", int'(busy), 1);
        post("single_tgl_c2", int'(sync_tgl), 0);
        cyc1();                                     // cycle 3: toggle visible
        post("single_tgl_c3", int'(sync_tgl), 1);
        c = 3; seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            cyc1(); c++;
            if (evt_done != '0) seen = 1;
        end
        post("single_done_seen", int'(seen), 1);
        post("single_done_val", int'(evt_done), 4);
        post("single_done_cyc", c, 10);
        cyc1();
        post("single_busy_after", int'(busy), 0);

        // ---- round-robin fairness with immediate loopback ----
        ack_dly = 0;
        do_reset();
        evt_req = 4'b1111; cyc1(); evt_req = '0;
        nd = 0;
        for (int k = 0; k < 60 && nd < 4; k++) begin
            cyc1();
            if (evt_done != '0) begin order[nd] = oh_idx(evt_done); nd++; end
        end
        post("rr_count", nd, 4);
        for (int i = 0; i < 4; i++) post("rr_order", (i < nd) ? order[i] : -1, i);
        cyc1();
        post("rr_tgl_end", int'(sync_tgl), 0);

        // ---- overflow and merge while requester 0 is in flight ----
        ack_dly = 3;
        do_reset();
        for (int i = 0; i < N; i++) cnt[i] = 0;
        evt_req = 4'b0001; cyc1(); evt_req = '0; cyc1();
        repeat (3) begin
            evt_req = 4'b0010; cyc1();
            if (evt_done != '0) cnt[oh_idx(evt_done)]++;
        end
        evt_req = '0;
        for (int k = 0; k < 40; k++) begin
            cyc1();
            if (evt_done != '0) cnt[oh_idx(evt_done)]++;
        end
        post("ovf_done0", cnt[0], 1);
        post("ovf_done1", cnt[1], 1);
        post("ovf_flags", int'(evt_ovf), 2);
        err_clr = 1; cyc1(); err_clr = 0;
        post("ovf_cleared", int'(evt_ovf), 0);

        // ---- set wins over a same-cycle grant clear ----
        ack_dly = 0;
        do_reset();
        got = 0;
        evt_req = 4'b1000; cyc1(); cyc1(); evt_req = '0;
        for (int k = 0; k < 30; k++) begin
            cyc1();
            if (evt_done == 4'b1000) got++;
        end
        post("setwins_done3", got, 2);
        post("setwins_no_ovf", int'(evt_ovf), 0);

        // ---- timeout with ack held ----
        ack_hold = 1;
        do_reset();
        evt_req = 4'b0001; cyc1(); evt_req = '0; cyc1(); cyc1();   // cycle 3: first WAIT cycle
        post("to_err_c3", int'(err_timeout), 0);
        repeat (7) cyc1();                                         // cycle 10: 8th WAIT cycle
        post("to_err_c10", int'(err_timeout), 0);
        cyc1();                                                    // cycle 11
        post("to_err_c11", int'(err_timeout), 1);
        post("to_busy_c11", int'(busy), 1);
        ack_hold = 0; ack_dly = 0;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            cyc1();
            if (evt_done != '0) seen = 1;
        end
        post("to_done_seen", int'(seen), 1);
        post("to_done_val", int'(evt_done), 1);
        post("to_err_sticky", int'(err_timeout), 1);
        err_clr = 1; cyc1(); err_clr = 0;
        post("to_err_clr", int'(err_timeout), 0);

        // ---- reset while waiting ----
        ack_hold = 1;
        do_reset();
        evt_req = 4'b0100; cyc1(); evt_req = '0; cyc1(); cyc1();
        post("rw_busy_before", int'(busy), 1);
        post("rw_tgl_before", int'(sync_tgl), 1);
        rst = 1; #1;
        post("rw_tgl_rst", int'(sync_tgl), 0);
        post("rw_busy_rst", int'(busy), 0);
        post("rw_done_rst", int'(evt_done), 0);
        repeat (3) cyc1();
        rst = 0; ack_hold = 0; ack_dly = 2;
        evt_req = 4'b0010; cyc1(); evt_req = '0;
        seen = 0;
        for (int k = 0; k < 30 && !seen; k++) begin
            cyc1();
            if (evt_done != '0) seen = 1;
        end
        post("rw_done_seen", int'(seen), 1);
        post("rw_done_val", int'(evt_done), 2);

        // ---- randomized traffic checked by the model ----
        ack_hold = 0; ack_dly = 1;
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            evt_req = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : '0;
            err_clr = ($urandom_range(0, 30) == 0);
            if (k % 200 == 199) begin
                ack_dly  = $urandom_range(0, 10);
                ack_hold = ($urandom_range(0, 5) == 0);
            end
            if (k % 700 == 650) begin
                do_reset();
            end else begin
                cyc1();
            end
        end
        evt_req = '0; err_clr = 0; ack_hold = 0;
        repeat (40) cyc1();
        tb_done = 1'b1;
    end

endmodule

// File: doc/nv_nvdla_sync_evt_arb.md
Name: nv_nvdla_sync_evt_arb

Overview:
- Source-side scheduler that shares one single-bit strict 3-flop synchronizer channel among NUM_REQ event requesters in the nvdla_core_clk domain.
- Captures event pulses as sticky pending bits and picks one pending bit round-robin.
- Drives a stable event ID, then toggles the crossing line (two-phase protocol) and waits for the returned, already-synchronized acknowledge toggle before issuing the next event.
- Provides done pulses, overflow flags and an ack-timeout watchdog.

Parameters:
- NUM_REQ, 4, number of event requesters (2..16).
- IDW, 2, width of event ID; must equal ceil(log2(NUM_REQ)), minimum 1.
- TIMEOUT_CYC, 1024, WAIT cycles before err_timeout sets; 16-bit counter, legal range 8..65535.

Ports:
- nvdla_core_clk  input  1  block clock.
- nvdla_core_rst  input  1  asynchronous, active-high reset.
- evt_req  input  NUM_REQ  per-requester single-cycle event pulse.
- ack_sync  input  1  acknowledge toggle returned from destination, already synchronized into nvdla_core_clk.
- err_clr  input  1  pulse; clears err_timeout and evt_ovf.
- sync_tgl  output  1  request toggle; feeds the synchronizer data input.
- sync_id  output  IDW  ID of the in-flight event; stable whenever sync_tgl != ack_sync.
- evt_done  output  NUM_REQ  one-cycle pulse when the event for requester i has been acknowledged.
- busy  output  1  high in SETUP or WAIT.
- evt_ovf  output  NUM_REQ  sticky; an event arrived while that requester's pending bit was already set.
- err_timeout  output  1  sticky; ack not seen within TIMEOUT_CYC cycles.

Behaviour:
- Interface: one clock (nvdla_core_clk). Reset nvdla_core_rst is asynchronous and active-high.
- Reset: all outputs are 0, pend = 0, rr_ptr = 0, state = IDLE, and the timeout counter is 0. Reset is legal mid-operation; the in-flight event is dropped with no evt_done. The system resets the destination side together, so ack_sync returns to 0.
- Pending capture: pend[i] is registered. It sets the cycle after evt_req[i]=1. If a set and a clear hit the same bit in the same cycle, set wins. If evt_req[i]=1 while pend[i]=1 and pend[i] is not being cleared that cycle, evt_ovf[i] sets and the events merge into one.
- Arbitration: round-robin starting at rr_ptr, wrapping from NUM_REQ-1 to 0. After completion, rr_ptr = granted+1, modulo NUM_REQ.
- FSM:
  - IDLE: if pend != 0, load sync_id = winner, clear pend[winner], go to SETUP. Otherwise stay.
  - SETUP (exactly 1 cycle): sync_tgl <= ~sync_tgl, clear the timeout counter, go to WAIT. sync_id has been stable for at least one full cycle before the toggle.
  - WAIT: when ack_sync == sync_tgl, pulse evt_done[sync_id] for 1 cycle and go to IDLE. Otherwise increment the counter, saturating. When the counter reaches TIMEOUT_CYC-1, set err_timeout and keep waiting; there is no abort.
- Latency: pend set at t+1 after evt_req at t, SETUP at t+2, toggle visible at t+3. Minimum issue-to-issue interval is 3 cycles plus ack round trip. IDLE may grant in the same cycle evt_done pulses.
- sync_id holds its value in IDLE after completion; it changes only on grant.
- err_clr: clears err_timeout and all evt_ovf. If err_clr coincides with a new set condition, the set wins.
- ack_sync changing in IDLE or SETUP (protocol violation) is ignored; only WAIT compares it.
- busy = (state != IDLE).

Decomposition:
- Shared package nv_nvdla_sync_evt_pkg holds:
  - the FSM state encoding (IDLE=2'd0, SETUP=2'd1, WAIT=2'd2);
  - the timeout counter width constant TOW=16;
  - a function computing IDW from NUM_REQ.
- One sub-module: nv_nvdla_sync_rr_arb. It is combinational round-robin select plus the registered rr_ptr; inputs pend and rr_ptr_update, output winner index and valid.

Test Plan:
- Single event: evt_req=4'b0100 at cycle 0; ack_sync loops back sync_tgl after 6 cycles → sync_id=2 by cycle 2, sync_tgl 0→1 at cycle 3, evt_done=4'b0100 for one cycle when ack_sync=1, busy=0 the next cycle.
- Round-robin fairness: pulse evt_req=4'b1111 once with immediate ack loopback → evt_done order 0,1,2,3; sync_tgl toggles 4 times and ends at 0.
- Overflow and merge: evt_req[1] pulsed at cycles 0, 1, 2 while requester 0 is in flight → evt_ovf=4'b0010, exactly one evt_done[1]; err_clr → evt_ovf=0.
- Set-wins: evt_req[3] pulsed in the same cycle its pend bit is granted → pend[3] stays 1 and requester 3 is served twice.
- Timeout: TIMEOUT_CYC=8, ack held constant → err_timeout=1 after 8 WAIT cycles, busy stays 1; a later ack gives evt_done; err_clr clears err_timeout.
- Reset mid-WAIT: assert nvdla_core_rst while busy=1 → sync_tgl=0, busy=0, no evt_done. After release, a new event completes normally.
